// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One result bit per cycle, 33 busy cycles per operation.
module muldiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_write,
   input  logic        lo_write,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_is_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [31:0] r_a_raw;
   logic [31:0] r_opnd;
   logic [63:0] r_acc;
   logic [4:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;

   logic        w_sa;
   logic        w_sb;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [32:0] w_add;
   logic [63:0] w_mul_nxt;
   logic        w_fits;
   logic [31:0] w_sub;
   logic [63:0] w_div_nxt;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   // Operand signs and magnitudes; unsigned ops use raw values.
   always_comb begin
      w_sa    = op[0] & a[31];
      w_sb    = op[0] & b[31];
      w_mag_a = w_sa ? (32'd0 - a) : a;
      w_mag_b = w_sb ? (32'd0 - b) : b;
   end

   // One shift-add step and one restoring-divide step.
   always_comb begin
      w_add     = {1'b0, r_acc[63:32]}
                + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
      w_mul_nxt = {w_add, r_acc[31:1]};
      w_fits    = (r_acc[63:31] >= {1'b0, r_opnd});
      w_sub     = r_acc[62:31] - r_opnd;
      w_div_nxt = w_fits ? {w_sub, r_acc[30:0], 1'b1}
                         : {r_acc[62:0], 1'b0};
   end

   // Sign correction applied when the result is written.
   always_comb begin
      w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
      w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
      w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (r_cnt == 5'd0) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: capture, iterate, and write HI/LO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_a_raw  <= 32'd0;
         r_opnd   <= 32'd0;
         r_acc    <= 64'd0;
         r_cnt    <= 5'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_div <= op[1];
                  r_neg_q  <= w_sa ^ w_sb;
                  r_neg_r  <= w_sa;
                  r_a_raw  <= a;
                  r_cnt    <= 5'd31;
                  r_busy   <= 1'b1;
                  if (op[1]) begin
                     r_opnd <= w_mag_b;
                     r_acc  <= {32'd0, w_mag_a};
                  end else begin
                     r_opnd <= w_mag_a;
                     r_acc  <= {32'd0, w_mag_b};
                  end
               end else begin
                  if (hi_write) r_hi <= a;
                  if (lo_write) r_lo <= a;
               end
            end
            S_RUN: begin
               r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
               r_cnt <= r_cnt - 5'd1;
            end
            S_FIX: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               if (!r_is_div) begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end else if (r_opnd == 32'd0) begin
                  r_hi <= r_a_raw;
                  r_lo <= 32'hFFFF_FFFF;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic, corner cases,
// busy/done timing, ignored inputs and asynchronous reset.
module tb_muldiv_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_write;
   logic        lo_write;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_vec;
   int n_err;
   logic [31:0] cur_hi;
   logic [31:0] cur_lo;

   muldiv_unit dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi_write (hi_write),
      .lo_write (lo_write),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one operation and check timing plus result.
   // inject: poke start/hi_write/a/b mid-run.
   // wr: assert hi/lo writes together with start.
   task automatic do_op(input string tag,
                        input logic [1:0] t_op,
                        input logic [31:0] t_a,
                        input logic [31:0] t_b,
                        input logic [31:0] e_hi,
                        input logic [31:0] e_lo,
                        input bit inject,
                        input bit wr);
      int cyc;
      bit saw_done;
      @(negedge clock);
      start    = 1'b1;
      op       = t_op;
      a        = t_a;
      b        = t_b;
      hi_write = wr;
      lo_write = wr;
      @(negedge clock);
      start    = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      a        = ~t_a;
      b        = ~t_b;
      cyc      = 0;
      saw_done = 1'b0;
      while (busy === 1'b1 && cyc < 100) begin
         if (done === 1'b1) saw_done = 1'b1;
         if (cyc == 10) begin
            chk({tag, " hold_hi"}, hi, cur_hi);
            chk({tag, " hold_lo"}, lo, cur_lo);
         end
         if (inject && cyc == 5) begin
            start    = 1'b1;
            op       = 2'b10;
            a        = 32'd100;
            b        = 32'd7;
            hi_write = 1'b1;
         end
         if (inject && cyc == 6) begin
            start    = 1'b0;
            hi_write = 1'b0;
         end
         cyc++;
         @(negedge clock);
      end
      chk({tag, " busy_cycles"}, 32'(cyc), 32'd33);
      chk({tag, " no_early_done"}, {31'd0, saw_done}, 32'd0);
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " hi"}, hi, e_hi);
      chk({tag, " lo"}, lo, e_lo);
      cur_hi = e_hi;
      cur_lo = e_lo;
      @(negedge clock);
      chk({tag, " done_1cyc"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      cur_hi   = 32'd0;
      cur_lo   = 32'd0;
      reset    = 1'b0;
      start    = 1'b0;
      op       = 2'b00;
      a        = 32'd0;
      b        = 32'd0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      reset = 1'b1;

      do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
      do_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
      do_op("mult_nn", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'd0, 32'd1, 0, 0);
      do_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
      do_op("div_negb", 2'b11, 32'd7, 32'hFFFF_FFFE,
            32'd1, 32'hFFFF_FFFD, 0, 0);
      do_op("divu_wr", 2'b10, 32'd7, 32'd2,
            32'd1, 32'd3, 0, 1);
      do_op("div_zero", 2'b11, 32'h1234_5678, 32'd0,
            32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
      do_op("div_zneg", 2'b11, 32'hFFFF_FFF9, 32'd0,
            32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0);
      do_op("divu_zero", 2'b10, 32'd5, 32'd0,
            32'd5, 32'hFFFF_FFFF, 0, 0);
      do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 32'h8000_0000, 0, 0);
      do_op("mult_inj", 2'b01, 32'd5, 32'd6,
            32'd0, 32'd30, 1, 0);

      @(negedge clock);
      hi_write = 1'b1;
      a        = 32'hCAFE_F00D;
      @(negedge clock);
      hi_write = 1'b0;
      chk("mthi hi", hi, 32'hCAFE_F00D);
      chk("mthi lo", lo, 32'd30);
      chk("mthi done", {31'd0, done}, 32'd0);
      lo_write = 1'b1;
      a        = 32'h0BAD_BEEF;
      @(negedge clock);
      lo_write = 1'b0;
      chk("mtlo lo", lo, 32'h0BAD_BEEF);
      chk("mtlo hi", hi, 32'hCAFE_F00D);

      start = 1'b1;
      op    = 2'b01;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      chk("rst_mid busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("rst_mid busy", {31'd0, busy}, 32'd0);
      chk("rst_mid hi", hi, 32'd0);
      chk("rst_mid lo", lo, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      begin
         bit saw;
         saw = 1'b0;
         repeat (40) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
         end
         chk("rst_mid quiet", {31'd0, saw}, 32'd0);
      end
      chk("rst_mid hi_after", hi, 32'd0);
      chk("rst_mid lo_after", lo, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath. Sits directly downstream of the general-purpose register file: it consumes the rs/rt read ports (`a`, `b`) and executes mult/multu/div/divu over 33 cycles while the rest of the core stalls on `busy`. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

## Interface
- No parameters; width fixed at 32.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  begin an operation; sampled only when idle.
- `op`  in  2  operation, sampled with `start`: 00 multu, 01 mult, 10 divu, 11 div.
- `a`  in  32  rs operand: multiplicand/dividend; also mthi/mtlo data.
- `b`  in  32  rt operand: multiplier/divisor.
- `hi_write`  in  1  mthi: HI <= `a`.
- `lo_write`  in  1  mtlo: LO <= `a`.
- `busy`  out  1  operation in progress; the core must stall.
- `done`  out  1  one-cycle pulse when a new HI/LO result is visible.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on a `start` edge, capture `op`, |a| and |b| (magnitudes for signed ops; raw values for unsigned ops), and the result signs. Load the iteration counter with 31. Go to RUN.
- RUN: one bit per cycle.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring division producing a 32-bit quotient and a 32-bit remainder.
  - Counter decrements each cycle; after the count-0 cycle, go to FIX.
- FIX: apply the sign correction, write HI/LO, go to IDLE.
  - mult: the 64-bit product is negated if the operand signs differ; HI = upper 32 bits, LO = lower 32 bits.
  - div/divu: LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Divide by zero (both signed and unsigned): LO = 0xFFFFFFFF, HI = the captured dividend `a`, unmodified.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while busy: ignored, with no effect on the current operation.
- `hi_write`/`lo_write`:
  - In IDLE: HI/LO update at the edge.
  - While busy: ignored.
  - Asserted together with `start` in IDLE: `start` wins and the writes are dropped.
- Reset, asynchronous and possibly mid-operation: state IDLE, `busy` = 0, `done` = 0, `hi` = `lo` = 0. The aborted result is never written.
- Operands are registered at `start`; later changes on `a`/`b` do not affect the result.

## Timing
- Edge E0 samples `start`. `busy` = 1 from just after E0 until just after E33 (33 cycles).
- RUN occupies edges E1..E32. The FIX edge E33 writes HI/LO.
- After E33: `busy` = 0, `done` = 1 for exactly one cycle, and `hi`/`lo` show the new values.
- A new `start` may be asserted in the cycle `done` is high; it is sampled at E34.
- `hi`/`lo` are held stable, at their old values, throughout RUN.
- mthi/mtlo latency: visible the cycle after the write edge. `done` does not pulse.
- All outputs are registered, with no combinational path from the inputs.

## Test plan
- multu with a = b = 0xFFFFFFFF: `busy` is high for 33 cycles, then `done` pulses, HI = 0xFFFFFFFE, LO = 0x00000001.
- mult with a = 0xFFFFFFFD (-3), b = 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- Division results:
  - div with a = 0xFFFFFFF9 (-7), b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu with a = 7, b = 2 → LO = 3, HI = 1.
- Divide by zero and overflow:
  - div with a = 0x12345678, b = 0 → LO = 0xFFFFFFFF, HI = 0x12345678.
  - div with a = 0x80000000, b = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Ignored inputs while busy: mid-operation `start` (op = divu) and `hi_write` with new `a`/`b` → the original result is unchanged, `done` pulses once, and `busy` is 33 cycles total. Then `hi_write` in IDLE with a = 0xCAFEF00D → HI = 0xCAFEF00D next cycle, LO unchanged.
- Reset mid-operation: assert `reset` = 0 at cycle 10 of a mult → immediately `busy` = 0 and `hi` = `lo` = 0. After release, no `done` pulse and HI/LO stay 0.
